// File: rtl/inst_fetcher.sv
// ---------------------------------------------------------------------------
// inst_fetcher
//
// Front end of the out-of-order core. Holds the PC, looks it up in a
// direct-mapped instruction cache (one 32-bit word per line), refills from
// the memory controller on a miss, predicts JAL / conditional branches with
// a table of 2-bit saturating counters, and hands one instruction per cycle
// to the decoder.
//
// Ports:
//   clk_in, rst_in (async, active-low), rdy_in (global enable)
//   rob_full, rs_full, lsb_full        back-end back-pressure
//   if_to_mc_req / if_to_mc_addr       refill request to memory controller
//   mc_to_if_done / mc_to_if_inst      refill response (one-cycle pulse)
//   rob_to_if_flush / _new_pc          redirect from the ROB
//   rob_to_if_br_commit / _br_pc / _br_taken   branch outcome training
//   if_to_dc_ready / _PC / _inst / _opType / _pred_br   issue to decoder
// ---------------------------------------------------------------------------
module inst_fetcher #(
    parameter int          ICACHE_BITS = 6,
    parameter int          BHT_BITS    = 8,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        rob_full,
    input  logic        rs_full,
    input  logic        lsb_full,
    output logic        if_to_mc_req,
    output logic [31:0] if_to_mc_addr,
    input  logic        mc_to_if_done,
    input  logic [31:0] mc_to_if_inst,
    input  logic        rob_to_if_flush,
    input  logic [31:0] rob_to_if_new_pc,
    input  logic        rob_to_if_br_commit,
    input  logic [31:0] rob_to_if_br_pc,
    input  logic        rob_to_if_br_taken,
    output logic        if_to_dc_ready,
    output logic [31:0] if_to_dc_PC,
    output logic [31:0] if_to_dc_inst,
    output logic [6:0]  if_to_dc_opType,
    output logic        if_to_dc_pred_br
);

    localparam int LINES = 1 << ICACHE_BITS;
    localparam int TAG_W = 32 - ICACHE_BITS - 2;
    localparam int BHT_N = 1 << BHT_BITS;

    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    // DISCARD: a redirect arrived while a refill was outstanding; the refill
    // must still be absorbed (and is still cached) but never issued.
    typedef enum logic [1:0] {
        IDLE,
        WAIT_MEM,
        DISCARD
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] memAddr_q, memAddr_d;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tagMem  [LINES];
    logic [31:0]      dataMem [LINES];
    logic [1:0]       bht_q   [BHT_N];

    logic        ready_q;
    logic [31:0] dcPc_q;
    logic [31:0] dcInst_q;
    logic        dcPred_q;

    logic                   stall;
    logic [ICACHE_BITS-1:0] pcIdx;
    logic [TAG_W-1:0]       pcTag;
    logic                   hit;
    logic [31:0]            fetchWord;
    logic [BHT_BITS-1:0]    predIdx;
    logic [BHT_BITS-1:0]    trainIdx;
    logic [31:0]            jImm;
    logic [31:0]            bImm;
    logic [31:0]            nextPc;
    logic                   predBr;
    logic                   issue;
    logic                   fill;
    logic [ICACHE_BITS-1:0] fillIdx;
    logic                   unusedBrPcBits;

    assign stall    = rob_full | rs_full | lsb_full;
    assign pcIdx    = pc_q[ICACHE_BITS+1:2];
    assign pcTag    = pc_q[31:ICACHE_BITS+2];
    assign hit      = valid_q[pcIdx] && (tagMem[pcIdx] == pcTag);
    assign predIdx  = pc_q[BHT_BITS+1:2];
    assign trainIdx = rob_to_if_br_pc[BHT_BITS+1:2];
    assign fillIdx  = memAddr_q[ICACHE_BITS+1:2];

    assign unusedBrPcBits = ^{rob_to_if_br_pc[31:BHT_BITS+2], rob_to_if_br_pc[1:0]};

    // While waiting on memory pc_q still equals the requested address, so the
    // returning word can be decoded against pc_q directly.
    assign fetchWord = (state_q == WAIT_MEM) ? mc_to_if_inst : dataMem[pcIdx];

    always_comb begin
        jImm   = {{11{fetchWord[31]}}, fetchWord[31], fetchWord[19:12],
                  fetchWord[20], fetchWord[30:21], 1'b0};
        bImm   = {{19{fetchWord[31]}}, fetchWord[31], fetchWord[7],
                  fetchWord[30:25], fetchWord[11:8], 1'b0};
        nextPc = pc_q + 32'd4;
        predBr = 1'b0;
        if (fetchWord[6:0] == OP_JAL) begin
            nextPc = pc_q + jImm;
            predBr = 1'b1;
        end else if ((fetchWord[6:0] == OP_BR) && bht_q[predIdx][1]) begin
            nextPc = pc_q + bImm;
            predBr = 1'b1;
        end
    end

    // Flush always wins over issue; a refill that completes together with a
    // flush is still cached because its data is correct for its own address.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        memAddr_d = memAddr_q;
        issue     = 1'b0;
        fill      = 1'b0;
        case (state_q)
            IDLE: begin
                if (rob_to_if_flush) begin
                    pc_d = rob_to_if_new_pc;
                end else if (hit) begin
                    if (!stall) begin
                        issue = 1'b1;
                        pc_d  = nextPc;
                    end
                end else begin
                    state_d   = WAIT_MEM;
                    memAddr_d = pc_q;
                end
            end
            WAIT_MEM: begin
                if (mc_to_if_done) begin
                    fill    = 1'b1;
                    state_d = IDLE;
                    if (rob_to_if_flush) begin
                        pc_d = rob_to_if_new_pc;
                    end else if (!stall) begin
                        issue = 1'b1;
                        pc_d  = nextPc;
                    end
                end else if (rob_to_if_flush) begin
                    pc_d    = rob_to_if_new_pc;
                    state_d = DISCARD;
                end
            end
            DISCARD: begin
                if (rob_to_if_flush) begin
                    pc_d = rob_to_if_new_pc;
                end
                if (mc_to_if_done) begin
                    fill    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            memAddr_q <= '0;
            valid_q   <= '0;
            ready_q   <= 1'b0;
            dcPc_q    <= '0;
            dcInst_q  <= '0;
            dcPred_q  <= 1'b0;
        end else if (rdy_in) begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            memAddr_q <= memAddr_d;
            ready_q   <= issue;
            if (fill) begin
                valid_q[fillIdx] <= 1'b1;
            end
            if (issue) begin
                dcPc_q   <= pc_q;
                dcInst_q <= fetchWord;
                dcPred_q <= predBr;
            end
        end else begin
            ready_q <= 1'b0;
        end
    end

    // Tag and data arrays need no reset: the valid bits gate every lookup.
    always_ff @(posedge clk_in) begin
        if (rdy_in && fill) begin
            tagMem[fillIdx]  <= memAddr_q[31:ICACHE_BITS+2];
            dataMem[fillIdx] <= mc_to_if_inst;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < BHT_N; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (rdy_in && rob_to_if_br_commit) begin
            if (rob_to_if_br_taken) begin
                if (bht_q[trainIdx] != 2'b11) begin
                    bht_q[trainIdx] <= bht_q[trainIdx] + 2'd1;
                end
            end else begin
                if (bht_q[trainIdx] != 2'b00) begin
                    bht_q[trainIdx] <= bht_q[trainIdx] - 2'd1;
                end
            end
        end
    end

    assign if_to_mc_req     = (state_q != IDLE);
    assign if_to_mc_addr    = memAddr_q;
    assign if_to_dc_ready   = ready_q;
    assign if_to_dc_PC      = dcPc_q;
    assign if_to_dc_inst    = dcInst_q;
    assign if_to_dc_opType  = dcInst_q[6:0];
    assign if_to_dc_pred_br = dcPred_q;

endmodule

// File: tb/tb_inst_fetcher.sv
// ---------------------------------------------------------------------------
// tb_inst_fetcher
//
// Bench for inst_fetcher. A small memory model answers refill requests after
// a fixed latency; expected issues come from a vector table and are queued
// into a scoreboard that is popped whenever the fetcher raises ready.
// ---------------------------------------------------------------------------
module tb_inst_fetcher;

    localparam int MEM_LAT = 3;
    localparam logic [31:0] BEQ_WORD = 32'hFE0008E3;
    localparam logic [31:0] JAL_WORD = 32'h100000EF;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        rob_full;
    logic        rs_full;
    logic        lsb_full;
    logic        if_to_mc_req;
    logic [31:0] if_to_mc_addr;
    logic        mc_to_if_done;
    logic [31:0] mc_to_if_inst;
    logic        rob_to_if_flush;
    logic [31:0] rob_to_if_new_pc;
    logic        rob_to_if_br_commit;
    logic [31:0] rob_to_if_br_pc;
    logic        rob_to_if_br_taken;
    logic        if_to_dc_ready;
    logic [31:0] if_to_dc_PC;
    logic [31:0] if_to_dc_inst;
    logic [6:0]  if_to_dc_opType;
    logic        if_to_dc_pred_br;

    inst_fetcher #(
        .ICACHE_BITS(6),
        .BHT_BITS(8),
        .RESET_PC(32'h0)
    ) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .rdy_in(rdy_in),
        .rob_full(rob_full),
        .rs_full(rs_full),
        .lsb_full(lsb_full),
        .if_to_mc_req(if_to_mc_req),
        .if_to_mc_addr(if_to_mc_addr),
        .mc_to_if_done(mc_to_if_done),
        .mc_to_if_inst(mc_to_if_inst),
        .rob_to_if_flush(rob_to_if_flush),
        .rob_to_if_new_pc(rob_to_if_new_pc),
        .rob_to_if_br_commit(rob_to_if_br_commit),
        .rob_to_if_br_pc(rob_to_if_br_pc),
        .rob_to_if_br_taken(rob_to_if_br_taken),
        .if_to_dc_ready(if_to_dc_ready),
        .if_to_dc_PC(if_to_dc_PC),
        .if_to_dc_inst(if_to_dc_inst),
        .if_to_dc_opType(if_to_dc_opType),
        .if_to_dc_pred_br(if_to_dc_pred_br)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int          phase;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred;
    } vec_t;

    vec_t        vecs[$];
    vec_t        issueQ[$];
    int          assertCount = 0;
    int          failCount   = 0;
    int          memCount    = 0;
    logic [31:0] reqAddrSeen = '0;
    logic [31:0] lastReqStart = '0;

    // addi x0, x0, <addr[11:0]>: opcode 0x13 with the address as immediate,
    // so every cached word is distinguishable by its contents.
    function automatic logic [31:0] addiAt(input logic [31:0] a);
        return {a[11:0], 20'h00013};
    endfunction

    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a == 32'h20) return BEQ_WORD;
        if (a == 32'h40) return JAL_WORD;
        return addiAt(a);
    endfunction

    task automatic addVec(input int ph, input logic [31:0] pc,
                          input logic [31:0] inst, input logic pred);
        vec_t v;
        v.phase = ph;
        v.pc    = pc;
        v.inst  = inst;
        v.pred  = pred;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int ph);
        foreach (vecs[i]) begin
            if (vecs[i].phase == ph) issueQ.push_back(vecs[i]);
        end
    endtask

    // One clock: sample #1 after the edge, then run the memory model and the
    // issue scoreboard.
    task automatic stepClock();
        vec_t        e;
        logic [31:0] ei;
        @(posedge clk_in);
        #1;
        if (mc_to_if_done) begin
            mc_to_if_done = 1'b0;
            memCount      = 0;
            checkOutput("req_drop_after_done", {31'b0, if_to_mc_req}, 32'd0);
        end else if (if_to_mc_req) begin
            if (memCount == 0) begin
                reqAddrSeen  = if_to_mc_addr;
                lastReqStart = if_to_mc_addr;
            end else begin
                checkOutput("req_addr_stable", if_to_mc_addr, reqAddrSeen);
            end
            memCount++;
            if (memCount == MEM_LAT) begin
                mc_to_if_done = 1'b1;
                mc_to_if_inst = memWord(if_to_mc_addr);
            end
        end else begin
            memCount = 0;
        end
        if (if_to_dc_ready) begin
            checkOutput("issue_expected", {31'b0, issueQ.size() != 0}, 32'd1);
            if (issueQ.size() != 0) begin
                e  = issueQ.pop_front();
                ei = e.inst;
                checkOutput("issue_pc", if_to_dc_PC, e.pc);
                checkOutput("issue_inst", if_to_dc_inst, ei);
                checkOutput("issue_opType", {25'b0, if_to_dc_opType}, {25'b0, ei[6:0]});
                checkOutput("issue_pred_br", {31'b0, if_to_dc_pred_br}, {31'b0, e.pred});
            end
        end
    endtask

    task automatic runUntilDrained(input int maxCycles);
        int n = 0;
        while (issueQ.size() != 0 && n < maxCycles) begin
            stepClock();
            n++;
        end
        checkOutput("drain", issueQ.size(), 32'd0);
        lsb_full = 1'b1;
    endtask

    task automatic flushTo(input logic [31:0] target);
        rob_to_if_flush  = 1'b1;
        rob_to_if_new_pc = target;
        stepClock();
        rob_to_if_flush  = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_req"},   {31'b0, if_to_mc_req}, 32'd0);
        checkOutput({tag, "_addr"},  if_to_mc_addr, 32'd0);
        checkOutput({tag, "_ready"}, {31'b0, if_to_dc_ready}, 32'd0);
        checkOutput({tag, "_pc"},    if_to_dc_PC, 32'd0);
        checkOutput({tag, "_inst"},  if_to_dc_inst, 32'd0);
        checkOutput({tag, "_op"},    {25'b0, if_to_dc_opType}, 32'd0);
        checkOutput({tag, "_pred"},  {31'b0, if_to_dc_pred_br}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;

        // Expected issue stream per phase.
        for (int a = 0; a < 32'h20; a += 4) addVec(1, a, addiAt(a), 1'b0);
        addVec(1, 32'h20, BEQ_WORD, 1'b0);
        addVec(1, 32'h24, addiAt(32'h24), 1'b0);
        for (int a = 32'h10; a < 32'h20; a += 4) addVec(2, a, addiAt(a), 1'b0);
        addVec(2, 32'h20, BEQ_WORD, 1'b1);
        addVec(2, 32'h10, addiAt(32'h10), 1'b0);
        addVec(3, 32'h40, JAL_WORD, 1'b1);
        addVec(3, 32'h140, addiAt(32'h140), 1'b0);
        addVec(4, 32'h200, addiAt(32'h200), 1'b0);
        addVec(5, 32'h80, addiAt(32'h80), 1'b0);
        addVec(6, 32'h10, addiAt(32'h10), 1'b0);
        addVec(6, 32'h14, addiAt(32'h14), 1'b0);
        addVec(7, 32'h0, addiAt(32'h0), 1'b0);

        rst_in              = 1'b1;
        rdy_in              = 1'b1;
        rob_full            = 1'b0;
        rs_full             = 1'b0;
        lsb_full            = 1'b0;
        mc_to_if_done       = 1'b0;
        mc_to_if_inst       = '0;
        rob_to_if_flush     = 1'b0;
        rob_to_if_new_pc    = '0;
        rob_to_if_br_commit = 1'b0;
        rob_to_if_br_pc     = '0;
        rob_to_if_br_taken  = 1'b0;
        #1 rst_in = 1'b0;
        stepClock();
        stepClock();
        checkAllZero("reset");
        rst_in = 1'b1;

        // Phase 1: cold fetch from reset, sequential misses, BEQ not predicted.
        $display("[TB] phase 1: cold fetch");
        applyStimulus(1);
        stepClock();
        checkOutput("first_req", {31'b0, if_to_mc_req}, 32'd1);
        checkOutput("first_addr", if_to_mc_addr, 32'h0);
        n = 0;
        while (!mc_to_if_done && n < 20) begin
            stepClock();
            n++;
        end
        stepClock();
        checkOutput("first_ready", {31'b0, if_to_dc_ready}, 32'd1);
        stepClock();
        checkOutput("second_req", {31'b0, if_to_mc_req}, 32'd1);
        checkOutput("second_addr", if_to_mc_addr, 32'h4);
        runUntilDrained(200);
        repeat (10) stepClock();

        // Phase 2: train BHT at 0x20 taken twice, replay loop from cache.
        $display("[TB] phase 2: cached loop with trained branch");
        rob_to_if_br_commit = 1'b1;
        rob_to_if_br_pc     = 32'h20;
        rob_to_if_br_taken  = 1'b1;
        flushTo(32'h10);
        stepClock();
        rob_to_if_br_commit = 1'b0;
        applyStimulus(2);
        lsb_full = 1'b0;
        for (int i = 0; i < 6; i++) begin
            stepClock();
            checkOutput("hit_ready", {31'b0, if_to_dc_ready}, 32'd1);
            checkOutput("hit_no_req", {31'b0, if_to_mc_req}, 32'd0);
        end
        lsb_full = 1'b1;
        checkOutput("phase2_drain", issueQ.size(), 32'd0);
        repeat (10) stepClock();

        // Phase 3: JAL +0x100 at 0x40.
        $display("[TB] phase 3: jal");
        flushTo(32'h40);
        applyStimulus(3);
        lsb_full = 1'b0;
        runUntilDrained(60);
        checkOutput("jal_target_req", lastReqStart, 32'h140);
        repeat (10) stepClock();

        // Phase 4: flush to 0x200 while refill of 0x80 is outstanding.
        $display("[TB] phase 4: flush during refill");
        lsb_full = 1'b0;
        flushTo(32'h80);
        stepClock();
        checkOutput("wait_req", {31'b0, if_to_mc_req}, 32'd1);
        checkOutput("wait_addr", if_to_mc_addr, 32'h80);
        flushTo(32'h200);
        checkOutput("discard_req", {31'b0, if_to_mc_req}, 32'd1);
        checkOutput("discard_addr", if_to_mc_addr, 32'h80);
        stepClock();
        checkOutput("discard_req_held", {31'b0, if_to_mc_req}, 32'd1);
        stepClock();
        checkOutput("discard_no_issue", {31'b0, if_to_dc_ready}, 32'd0);
        applyStimulus(4);
        stepClock();
        checkOutput("redirect_req", {31'b0, if_to_mc_req}, 32'd1);
        checkOutput("redirect_addr", if_to_mc_addr, 32'h200);
        runUntilDrained(40);
        repeat (10) stepClock();

        // Phase 5: the discarded refill left 0x80 cached.
        $display("[TB] phase 5: discarded word hits");
        flushTo(32'h80);
        applyStimulus(5);
        lsb_full = 1'b0;
        stepClock();
        checkOutput("discarded_hit_ready", {31'b0, if_to_dc_ready}, 32'd1);
        checkOutput("discarded_hit_no_req", {31'b0, if_to_mc_req}, 32'd0);
        lsb_full = 1'b1;
        repeat (10) stepClock();

        // Phase 6: rs_full / rob_full hold a hit; rdy_in freezes everything.
        $display("[TB] phase 6: stall and rdy");
        flushTo(32'h10);
        applyStimulus(6);
        lsb_full = 1'b0;
        rs_full  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            stepClock();
            checkOutput("rs_full_hold", {31'b0, if_to_dc_ready}, 32'd0);
        end
        rs_full  = 1'b0;
        rob_full = 1'b1;
        stepClock();
        checkOutput("rob_full_hold", {31'b0, if_to_dc_ready}, 32'd0);
        rob_full = 1'b0;
        stepClock();
        checkOutput("stall_release_ready", {31'b0, if_to_dc_ready}, 32'd1);
        stepClock();
        checkOutput("pre_rdy_ready", {31'b0, if_to_dc_ready}, 32'd1);
        rdy_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            stepClock();
            checkOutput("rdy_low_ready", {31'b0, if_to_dc_ready}, 32'd0);
            checkOutput("rdy_low_pc_hold", if_to_dc_PC, 32'h14);
        end
        lsb_full = 1'b1;
        rdy_in   = 1'b1;
        checkOutput("phase6_drain", issueQ.size(), 32'd0);
        repeat (10) stepClock();

        // Phase 7: reset in the middle of a refill.
        $display("[TB] phase 7: reset during refill");
        flushTo(32'h300);
        stepClock();
        checkOutput("pre_reset_req", {31'b0, if_to_mc_req}, 32'd1);
        checkOutput("pre_reset_addr", if_to_mc_addr, 32'h300);
        #2 rst_in = 1'b0;
        #1;
        checkAllZero("midreset");
        stepClock();
        rst_in = 1'b1;
        applyStimulus(7);
        lsb_full = 1'b0;
        stepClock();
        checkOutput("post_reset_req", {31'b0, if_to_mc_req}, 32'd1);
        checkOutput("post_reset_addr", if_to_mc_addr, 32'h0);
        runUntilDrained(40);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
